terminal_cmd_exec: RTL and testbench

//  Command executor started by the terminal control FSM once the rx command byte is buffered.
//  - Decodes one ASCII command byte and applies it to an LED register.
//  - Sends an ASCII reply through the UART transmitter, then pulses end-of-FSM back to the controller.
//  - Sits between the terminal controller (start/done) and uart_tx (byte handshake).

---
 rtl/terminal_pkg.sv | 34 +++
 rtl/terminal_msg_rom.sv | 57 +++++
 rtl/terminal_cmd_exec.sv | 108 ++++++++++
 tb/tb_terminal_cmd_exec.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/terminal_pkg.sv
// rtl/terminal_pkg.sv - shared state, ASCII and message-select definitions for the terminal command executor.
package terminal_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_SEND    = 3'd2;
   localparam logic [2:0] S_WAIT_LO = 3'd3;
   localparam logic [2:0] S_WAIT_HI = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = S_IDLE,
      DECODE  = S_DECODE,
      SEND    = S_SEND,
      WAIT_LO = S_WAIT_LO,
      WAIT_HI = S_WAIT_HI,
      DONE    = S_DONE
   } state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_K  = 8'h4B;
   localparam logic [7:0] ASCII_E  = 8'h45;
   localparam logic [7:0] ASCII_C  = 8'h43;
   localparam logic [7:0] ASCII_S  = 8'h53;
   localparam logic [7:0] ASCII_0  = 8'h30;

   typedef enum logic [1:0] {
      MSG_OK   = 2'd0,
      MSG_ERR  = 2'd1,
      MSG_STAT = 2'd2
   } msg_sel_t;

endpackage

// File: rtl/terminal_msg_rom.sv
// rtl/terminal_msg_rom.sv - combinational reply byte/length lookup; TERMINAL_ECHO_EN prepends the command byte.
module terminal_msg_rom
   import terminal_pkg::*;
(
   input  msg_sel_t    msg_sel,
   input  logic [2:0]  idx,
   input  logic [7:0]  cmd,
   input  logic [7:0]  led,
   output logic [7:0]  byte_o,
   output logic [2:0]  msg_len
);

   logic [2:0] body_idx;
   logic [2:0] body_len;
   logic [7:0] body_byte;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (ASCII_0 + {4'd0, n}) : (8'h37 + {4'd0, n});
   endfunction

   always_comb begin
      body_len  = (msg_sel == MSG_STAT) ? 3'd4 : 3'd3;
      body_byte = ASCII_LF;
`ifdef TERMINAL_ECHO_EN
      body_idx  = idx - 3'd1;
      msg_len   = body_len + 3'd1;
`else
      body_idx  = idx;
      msg_len   = body_len;
`endif
      if (msg_sel == MSG_STAT) begin
         case (body_idx)
            3'd0:    body_byte = hex_char(led[7:4]);
            3'd1:    body_byte = hex_char(led[3:0]);
            3'd2:    body_byte = ASCII_CR;
            default: body_byte = ASCII_LF;
         endcase
      end else begin
         case (body_idx)
            3'd0:    body_byte = (msg_sel == MSG_OK) ? ASCII_K : ASCII_E;
            3'd1:    body_byte = ASCII_CR;
            default: body_byte = ASCII_LF;
         endcase
      end
`ifdef TERMINAL_ECHO_EN
      byte_o = (idx == 3'd0) ? cmd : body_byte;
`else
      byte_o = body_byte;
`endif
   end

`ifndef TERMINAL_ECHO_EN
   logic unused_cmd;
   assign unused_cmd = ^cmd;
`endif

endmodule

// File: rtl/terminal_cmd_exec.sv
// rtl/terminal_cmd_exec.sv - command executor: LED register, reply sequencer to uart_tx (TERMINAL_ECHO_EN echoes the command).
module terminal_cmd_exec
   import terminal_pkg::*;
#(
   parameter int NLED = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [7:0]      cmd_i,
   input  logic            eot_i,
   output logic            tx_start_o,
   output logic [7:0]      tx_data_o,
   output logic [NLED-1:0] led_o,
   output logic            eofsm_o
);

   state_t          state;
   msg_sel_t        msg_sel;
   logic [7:0]      cmd_q;
   logic [NLED-1:0] led_q;
   logic [2:0]      idx;
   logic [7:0]      led_pad;
   logic [7:0]      rom_byte;
   logic [2:0]      msg_len;
   logic [2:0]      digit;
   logic            is_digit;

   assign led_o    = led_q;
   assign digit    = cmd_q[2:0];
   assign is_digit = (cmd_q[7:3] == ASCII_0[7:3]) && ({29'd0, digit} < NLED);

   always_comb begin
      led_pad = '0;
      led_pad[NLED-1:0] = led_q;
   end

   terminal_msg_rom u_rom (
      .msg_sel (msg_sel),
      .idx     (idx),
      .cmd     (cmd_q),
      .led     (led_pad),
      .byte_o  (rom_byte),
      .msg_len (msg_len)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         msg_sel    <= MSG_OK;
         cmd_q      <= '0;
         led_q      <= '0;
         idx        <= '0;
         tx_start_o <= 1'b0;
         tx_data_o  <= '0;
         eofsm_o    <= 1'b0;
      end else begin
         tx_start_o <= 1'b0;
         eofsm_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  cmd_q <= cmd_i;
                  state <= DECODE;
               end
            end
            DECODE: begin
               idx   <= '0;
               state <= SEND;
               if (is_digit) begin
                  led_q   <= led_q ^ (NLED'(1) << digit);
                  msg_sel <= MSG_OK;
               end else if (cmd_q == ASCII_C) begin
                  led_q   <= '0;
                  msg_sel <= MSG_OK;
               end else if (cmd_q == ASCII_S) begin
                  msg_sel <= MSG_STAT;
               end else begin
                  msg_sel <= MSG_ERR;
               end
            end
            // Byte and strobe are registered here, so tx_start_o is seen during the first WAIT_LO cycle.
            SEND: begin
               tx_data_o  <= rom_byte;
               tx_start_o <= 1'b1;
               state      <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!eot_i) state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (eot_i) begin
                  if (idx + 3'd1 < msg_len) begin
                     idx   <= idx + 3'd1;
                     state <= SEND;
                  end else begin
                     eofsm_o <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_terminal_cmd_exec.sv
// tb/tb_terminal_cmd_exec.sv - scoreboard bench for terminal_cmd_exec (NLED=8 and NLED=4 instances).
module tb_terminal_cmd_exec;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b;
   logic [7:0] cmd_a, cmd_b;
   logic       eot_a, eot_b;
   logic       tx_start_a, tx_start_b;
   logic [7:0] data_a, data_b;
   logic [7:0] led_a;
   logic [3:0] led_b;
   logic       eof_a, eof_b;

   int checks = 0;
   int failures = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int eof_cnt_a = 0, eof_cnt_b = 0;
   int tx_cnt_a = 0;
   int ucnt_a, ucnt_b;

   always #5 clk = ~clk;

   terminal_cmd_exec #(.NLED(8)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .cmd_i(cmd_a), .eot_i(eot_a),
      .tx_start_o(tx_start_a), .tx_data_o(data_a), .led_o(led_a), .eofsm_o(eof_a)
   );

   terminal_cmd_exec #(.NLED(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .cmd_i(cmd_b), .eot_i(eot_b),
      .tx_start_o(tx_start_b), .tx_data_o(data_b), .led_o(led_b), .eofsm_o(eof_b)
   );

   // uart_tx model: eot drops for 10 cycles after each accepted start
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ucnt_a <= 0;
         ucnt_b <= 0;
      end else begin
         if (tx_start_a) ucnt_a <= 10; else if (ucnt_a != 0) ucnt_a <= ucnt_a - 1;
         if (tx_start_b) ucnt_b <= 10; else if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
      end
   end
   assign eot_a = (ucnt_a == 0);
   assign eot_b = (ucnt_b == 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tx_start_a) begin
         tx_cnt_a++;
         if (q_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_tx_unexpected actual=%h required=none", data_a);
         end else chk("a_tx_byte", 32'(data_a), 32'(q_a.pop_front()));
      end
      if (tx_start_b) begin
         if (q_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_tx_unexpected actual=%h required=none", data_b);
         end else chk("b_tx_byte", 32'(data_b), 32'(q_b.pop_front()));
      end
      if (eof_a) eof_cnt_a++;
      if (eof_b) eof_cnt_b++;
   end

   task automatic push(input int inst, input logic [7:0] b);
      if (inst == 0) q_a.push_back(b); else q_b.push_back(b);
   endtask

   task automatic run(input int inst, input logic [7:0] c, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input int n);
      logic [7:0] bs[4];
      int e0, k;
      bs = '{b0, b1, b2, b3};
`ifdef TERMINAL_ECHO_EN
      push(inst, c);
`endif
      for (int i = 0; i < n; i++) push(inst, bs[i]);
      e0 = (inst == 0) ? eof_cnt_a : eof_cnt_b;
      @(negedge clk);
      if (inst == 0) begin start_a = 1'b1; cmd_a = c; end else begin start_b = 1'b1; cmd_b = c; end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; cmd_a = 8'h55; cmd_b = 8'h55;
      k = 0;
      while (((inst == 0) ? eof_cnt_a : eof_cnt_b) == e0 && k < 2000) begin
         @(posedge clk);
         k++;
      end
      chk("eofsm_timeout", 32'(k < 2000), 32'd1);
      repeat (4) @(negedge clk);
      chk("eofsm_count", 32'((inst == 0) ? eof_cnt_a : eof_cnt_b), 32'(e0 + 1));
      chk("queue_drained", 32'((inst == 0) ? q_a.size() : q_b.size()), 32'd0);
   endtask

   initial begin
      int k, e0, t0;
      logic [7:0] rst_bytes[2];
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_led", 32'(led_a), 32'h00);
      chk("reset_tx_start", 32'(tx_start_a), 32'd0);
      chk("reset_tx_data", 32'(data_a), 32'h00);
      chk("reset_eofsm", 32'(eof_a), 32'd0);

      run(0, "3", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      chk("led_after_3", 32'(led_a), 32'h08);
      run(0, "3", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "0", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "2", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "5", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "7", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      chk("led_a5", 32'(led_a), 32'hA5);
      run(0, "S", 8'h41, 8'h35, 8'h0D, 8'h0A, 4);
      chk("led_after_S", 32'(led_a), 32'hA5);
      run(0, "x", 8'h45, 8'h0D, 8'h0A, 8'h00, 3);
      chk("led_after_x", 32'(led_a), 32'hA5);
      run(0, "8", 8'h45, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "s", 8'h45, 8'h0D, 8'h0A, 8'h00, 3);
      chk("led_after_errs", 32'(led_a), 32'hA5);
      run(0, "1", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "3", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "4", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "6", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      chk("led_ff", 32'(led_a), 32'hFF);
      run(0, "S", 8'h46, 8'h46, 8'h0D, 8'h0A, 4);

      // 'C' with a stray start pulse injected while the FSM waits in WAIT_HI
      fork
         run(0, "C", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
         begin
            k = 0;
            while (eot_a && k < 500) begin @(negedge clk); k++; end
            while (!eot_a && k < 500) begin @(negedge clk); k++; end
            start_a = 1'b1; cmd_a = "3";
            @(negedge clk);
            start_a = 1'b0;
         end
      join
      repeat (60) @(negedge clk);
      chk("led_after_C", 32'(led_a), 32'h00);
      chk("queue_after_C", 32'(q_a.size()), 32'd0);

      // reset during the second reply byte of '5'
`ifdef TERMINAL_ECHO_EN
      rst_bytes = '{8'h35, 8'h4B};
`else
      rst_bytes = '{8'h4B, 8'h0D};
`endif
      q_a.push_back(rst_bytes[0]);
      q_a.push_back(rst_bytes[1]);
      e0 = eof_cnt_a;
      t0 = tx_cnt_a;
      start_a = 1'b1; cmd_a = "5";
      @(negedge clk);
      start_a = 1'b0;
      k = 0;
      while (tx_cnt_a < t0 + 2 && k < 500) begin @(posedge clk); k++; end
      chk("second_byte_timeout", 32'(k < 500), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_tx_start", 32'(tx_start_a), 32'd0);
      chk("midrst_tx_data", 32'(data_a), 32'h00);
      chk("midrst_led", 32'(led_a), 32'h00);
      chk("midrst_eofsm", 32'(eof_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("midrst_no_eofsm", 32'(eof_cnt_a), 32'(e0));
      chk("midrst_queue", 32'(q_a.size()), 32'd0);
      run(0, "0", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      chk("led_after_rst_0", 32'(led_a), 32'h01);
      run(0, "1", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      run(0, "0", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      chk("led_02", 32'(led_a), 32'h02);

      // NLED=4 instance: digits 4..7 are errors
      run(1, "6", 8'h45, 8'h0D, 8'h0A, 8'h00, 3);
      chk("b_led_after_6", 32'(led_b), 32'h0);
      run(1, "3", 8'h4B, 8'h0D, 8'h0A, 8'h00, 3);
      chk("b_led_after_3", 32'(led_b), 32'h8);
      run(1, "S", 8'h30, 8'h38, 8'h0D, 8'h0A, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
